// File: rtl/player_2_ctl.sv
// Player-2 motion and animation controller: samples keys once per frame (vsync rising edge),
// owns the sprite position, the walk pose and the jump arc for the player-2 draw stage.

package state_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEFT1  = 3'd1,
        LEFT2  = 3'd2,
        RIGHT1 = 3'd3,
        RIGHT2 = 3'd4
    } State;
endpackage

module player_2_ctl #(
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 984,
    parameter int unsigned X_START     = 200,
    parameter int unsigned X_STEP      = 4,
    parameter int unsigned Y_GROUND    = 100,
    parameter int unsigned JUMP_H      = 80,
    parameter int unsigned JUMP_STEP   = 4,
    parameter int unsigned ANIM_FRAMES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vsync,
    input  logic            key_left,
    input  logic            key_right,
    input  logic            key_jump,
    output logic [11:0]     xpos_player2,
    output logic [11:0]     ypos_player2,
    output state_pkg::State state,
    output logic            airborne
);
    import state_pkg::*;

    localparam int unsigned W  = 12;
    localparam int unsigned CW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    localparam logic [W-1:0]  X_MIN_W     = W'(X_MIN);
    localparam logic [W-1:0]  X_START_W   = W'(X_START);
    localparam logic [W-1:0]  X_STEP_W    = W'(X_STEP);
    localparam logic [W:0]    X_STEP_WX   = (W+1)'(X_STEP);
    localparam logic [W:0]    X_MAX_WX    = (W+1)'(X_MAX);
    localparam logic [W-1:0]  Y_GROUND_W  = W'(Y_GROUND);
    localparam logic [W:0]    Y_GROUND_WX = (W+1)'(Y_GROUND);
    localparam logic [W-1:0]  JUMP_H_W    = W'(JUMP_H);
    localparam logic [W-1:0]  JUMP_STEP_W = W'(JUMP_STEP);
    localparam logic [W:0]    JUMP_STEP_WX = (W+1)'(JUMP_STEP);
    localparam logic [CW-1:0] ANIM_LAST   = CW'(ANIM_FRAMES - 1);

    typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} jump_t;
    typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_LEFT = 2'd1, DIR_RIGHT = 2'd2} dir_t;

    logic          vsync_d;
    logic [CW-1:0] anim_cnt, anim_cnt_n;
    logic          phase, phase_n;
    dir_t          prev_dir, prev_dir_n;
    jump_t         jump_state, jump_state_n;
    logic          jump_armed, jump_armed_n;
    logic [W-1:0]  xpos_n, ypos_n;
    State          state_n;
    logic          airborne_n;

    logic          tick_c;
    dir_t          dir_c;
    logic [W:0]    x_sum_c, y_sum_c;
    logic [W-1:0]  x_left_c, x_right_c, y_rise_c, y_fall_c;
    logic          apex_c;

    // Saturating step candidates; 13-bit sums keep the upper limit compares overflow-free
    always_comb begin
        tick_c    = vsync & ~vsync_d;
        dir_c     = DIR_NONE;
        if (key_left && !key_right)
            dir_c = DIR_LEFT;
        else if (key_right && !key_left)
            dir_c = DIR_RIGHT;
        x_sum_c   = {1'b0, xpos_player2} + X_STEP_WX;
        y_sum_c   = {1'b0, ypos_player2} + JUMP_STEP_WX;
        x_left_c  = (xpos_player2 >= X_MIN_W + X_STEP_W) ? xpos_player2 - X_STEP_W : X_MIN_W;
        x_right_c = (x_sum_c <= X_MAX_WX) ? x_sum_c[W-1:0] : X_MAX_WX[W-1:0];
        y_rise_c  = (ypos_player2 >= JUMP_STEP_W) ? ypos_player2 - JUMP_STEP_W : '0;
        y_fall_c  = (y_sum_c >= Y_GROUND_WX) ? Y_GROUND_W : y_sum_c[W-1:0];
        apex_c    = (Y_GROUND_W - y_rise_c) >= JUMP_H_W;
    end

    // Next-state logic: everything holds except in a tick cycle
    always_comb begin
        xpos_n       = xpos_player2;
        ypos_n       = ypos_player2;
        state_n      = state;
        airborne_n   = airborne;
        anim_cnt_n   = anim_cnt;
        phase_n      = phase;
        prev_dir_n   = prev_dir;
        jump_state_n = jump_state;
        jump_armed_n = jump_armed;

        if (tick_c) begin
            case (dir_c)
                DIR_LEFT:  xpos_n = x_left_c;
                DIR_RIGHT: xpos_n = x_right_c;
                default:   xpos_n = xpos_player2;
            endcase

            if (dir_c == DIR_NONE || dir_c != prev_dir) begin
                anim_cnt_n = '0;
                phase_n    = 1'b0;
            end else if (anim_cnt == ANIM_LAST) begin
                anim_cnt_n = '0;
                phase_n    = ~phase;
            end else begin
                anim_cnt_n = anim_cnt + CW'(1);
            end
            prev_dir_n = dir_c;

            case (dir_c)
                DIR_LEFT:  state_n = phase_n ? LEFT2 : LEFT1;
                DIR_RIGHT: state_n = phase_n ? RIGHT2 : RIGHT1;
                default:   state_n = IDLE;
            endcase

            // The launching tick already takes the first upward step
            case (jump_state)
                GROUND: begin
                    if (key_jump && jump_armed) begin
                        ypos_n       = y_rise_c;
                        jump_armed_n = 1'b0;
                        jump_state_n = apex_c ? FALL : RISE;
                    end
                end
                RISE: begin
                    ypos_n       = y_rise_c;
                    jump_state_n = apex_c ? FALL : RISE;
                end
                FALL: begin
                    ypos_n       = y_fall_c;
                    jump_state_n = (y_fall_c == Y_GROUND_W) ? GROUND : FALL;
                end
                default: jump_state_n = GROUND;
            endcase
            if (!key_jump)
                jump_armed_n = 1'b1;
            airborne_n = (jump_state_n != GROUND);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d      <= 1'b0;
            xpos_player2 <= X_START_W;
            ypos_player2 <= Y_GROUND_W;
            state        <= IDLE;
            airborne     <= 1'b0;
            anim_cnt     <= '0;
            phase        <= 1'b0;
            prev_dir     <= DIR_NONE;
            jump_state   <= GROUND;
            jump_armed   <= 1'b1;
        end else begin
            vsync_d      <= vsync;
            xpos_player2 <= xpos_n;
            ypos_player2 <= ypos_n;
            state        <= state_n;
            airborne     <= airborne_n;
            anim_cnt     <= anim_cnt_n;
            phase        <= phase_n;
            prev_dir     <= prev_dir_n;
            jump_state   <= jump_state_n;
            jump_armed   <= jump_armed_n;
        end
    end

endmodule

// File: tb/tb_player_2_ctl.sv
// Scoreboard bench for player_2_ctl: a behavioural model queues the expected outputs per frame,
// a monitor pops and compares them on the update edge and again while they must hold.
module tb_player_2_ctl;
    import state_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        key_left = 1'b0;
    logic        key_right = 1'b0;
    logic        key_jump = 1'b0;
    logic [11:0] xpos_player2;
    logic [11:0] ypos_player2;
    State        state;
    logic        airborne;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   x;
        int   y;
        State st;
        bit   air;
    } exp_t;

    exp_t sb[$];

    // Behavioural model state
    int   m_x, m_y, m_cnt, m_prev, m_jump;
    bit   m_phase, m_armed, m_air;
    State m_st;

    player_2_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .vsync        (vsync),
        .key_left     (key_left),
        .key_right    (key_right),
        .key_jump     (key_jump),
        .xpos_player2 (xpos_player2),
        .ypos_player2 (ypos_player2),
        .state        (state),
        .airborne     (airborne)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_x = 200; m_y = 100; m_st = IDLE; m_air = 1'b0;
        m_cnt = 0; m_phase = 1'b0; m_prev = 0; m_jump = 0; m_armed = 1'b1;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit j);
        int dir;
        dir = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
        if (dir == 1) m_x = (m_x >= 4) ? m_x - 4 : 0;
        if (dir == 2) m_x = (m_x + 4 <= 984) ? m_x + 4 : 984;
        if (dir == 0 || dir != m_prev) begin
            m_cnt = 0; m_phase = 1'b0;
        end else if (m_cnt == 7) begin
            m_cnt = 0; m_phase = !m_phase;
        end else begin
            m_cnt++;
        end
        m_prev = dir;
        m_st = (dir == 0) ? IDLE : (dir == 1) ? (m_phase ? LEFT2 : LEFT1) : (m_phase ? RIGHT2 : RIGHT1);
        if (m_jump == 0 && j && m_armed) begin
            m_armed = 1'b0;
            m_jump = 1;
        end else if (m_jump == 2) begin
            m_y = m_y + 4;
            if (m_y >= 100) begin m_y = 100; m_jump = 0; end
        end
        if (m_jump == 1) begin
            m_y = m_y - 4;
            if (100 - m_y >= 80) m_jump = 2;
        end
        if (!j) m_armed = 1'b1;
        m_air = (m_jump != 0);
    endtask

    // One video frame: keys and vsync change on a falling edge, tick edge follows
    task automatic frame(input bit l, input bit r, input bit j);
        exp_t e;
        @(negedge clk);
        key_left = l; key_right = r; key_jump = j;
        model_tick(l, r, j);
        e.x = m_x; e.y = m_y; e.st = m_st; e.air = m_air;
        sb.push_back(e);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: update lands on the edge after vsync rises, then must hold
    always begin
        exp_t e;
        @(posedge vsync);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: output update with no expected entry");
        end else begin
            e = sb.pop_front();
            if (xpos_player2 !== 12'(e.x) || ypos_player2 !== 12'(e.y) ||
                state !== e.st || airborne !== e.air) begin
                errors++;
                $display("FAIL tick_update: got x=%0d y=%0d st=%0d air=%0d, expected x=%0d y=%0d st=%0d air=%0d",
                         xpos_player2, ypos_player2, state, airborne, e.x, e.y, e.st, e.air);
            end
            @(posedge clk);
            @(posedge clk);
            #1;
            checks++;
            if (xpos_player2 !== 12'(e.x) || ypos_player2 !== 12'(e.y) ||
                state !== e.st || airborne !== e.air) begin
                errors++;
                $display("FAIL between_ticks_hold: got x=%0d y=%0d st=%0d air=%0d, expected x=%0d y=%0d st=%0d air=%0d",
                         xpos_player2, ypos_player2, state, airborne, e.x, e.y, e.st, e.air);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (xpos_player2 !== 12'd200 || ypos_player2 !== 12'd100 || state !== IDLE || airborne !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got x=%0d y=%0d st=%0d air=%0d, expected 200 100 %0d 0",
                     xpos_player2, ypos_player2, state, airborne, IDLE);
        end
        rst = 1'b0;
        model_reset();
        repeat (3) frame(1'b0, 1'b0, 1'b0);
        checks++;
        if (xpos_player2 !== 12'd200 || state !== IDLE) begin
            errors++;
            $display("FAIL idle_frames: got x=%0d st=%0d, expected 200 %0d", xpos_player2, state, IDLE);
        end
    endtask

    task automatic test_walk_right();
        State want;
        for (int i = 0; i < 20; i++) begin
            frame(1'b0, 1'b1, 1'b0);
            want = ((i < 8) || (i >= 16)) ? RIGHT1 : RIGHT2;
            checks++;
            if (state !== want) begin
                errors++;
                $display("FAIL walk_pose frame %0d: got %0d expected %0d", i + 1, state, want);
            end
        end
        checks++;
        if (xpos_player2 !== 12'd280) begin
            errors++;
            $display("FAIL walk_xpos: got %0d expected 280", xpos_player2);
        end
    endtask

    task automatic test_limits();
        repeat (70) frame(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) frame(1'b1, 1'b0, 1'b0);
            checks++;
            if (xpos_player2 !== 12'd0) begin
                errors++;
                $display("FAIL left_limit step %0d: got %0d expected 0", i, xpos_player2);
            end
        end
        repeat (246) frame(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) frame(1'b0, 1'b1, 1'b0);
            checks++;
            if (xpos_player2 !== 12'd984) begin
                errors++;
                $display("FAIL right_limit step %0d: got %0d expected 984", i, xpos_player2);
            end
        end
    endtask

    task automatic test_jump();
        int want_y;
        for (int i = 0; i < 60; i++) begin
            frame(1'b0, 1'b0, 1'b1);
            want_y = (i < 20) ? 96 - 4 * i : ((i < 40) ? 24 + 4 * (i - 20) : 100);
            checks++;
            if (ypos_player2 !== 12'(want_y) || airborne !== (i < 39)) begin
                errors++;
                $display("FAIL jump_arc frame %0d: got y=%0d air=%0d expected y=%0d air=%0d",
                         i + 1, ypos_player2, airborne, want_y, (i < 39));
            end
        end
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1);
        checks++;
        if (ypos_player2 !== 12'd96 || airborne !== 1'b1) begin
            errors++;
            $display("FAIL rejump: got y=%0d air=%0d expected 96 1", ypos_player2, airborne);
        end
        repeat (39) frame(1'b0, 1'b0, 1'b0);
        checks++;
        if (ypos_player2 !== 12'd100 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL rejump_land: got y=%0d air=%0d expected 100 0", ypos_player2, airborne);
        end
    endtask

    task automatic test_both_keys();
        logic [11:0] x0;
        x0 = xpos_player2;
        frame(1'b1, 1'b1, 1'b0);
        checks++;
        if (xpos_player2 !== x0 || state !== IDLE) begin
            errors++;
            $display("FAIL both_keys: got x=%0d st=%0d expected x=%0d st=%0d", xpos_player2, state, x0, IDLE);
        end
        repeat (3) frame(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            frame(1'b0, 1'b1, 1'b0);
            checks++;
            if (state !== ((i < 8) ? RIGHT1 : RIGHT2)) begin
                errors++;
                $display("FAIL switch_pose frame %0d: got %0d expected %0d", i + 1, state, (i < 8) ? RIGHT1 : RIGHT2);
            end
        end
    endtask

    task automatic test_reset_mid_jump();
        repeat (10) frame(1'b0, 1'b1, 1'b1);
        checks++;
        if (ypos_player2 !== 12'd60 || airborne !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_jump: got y=%0d air=%0d expected 60 1", ypos_player2, airborne);
        end
        @(negedge clk);
        rst = 1'b1;
        key_right = 1'b0; key_jump = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (xpos_player2 !== 12'd200 || ypos_player2 !== 12'd100 || state !== IDLE || airborne !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_jump: got x=%0d y=%0d st=%0d air=%0d expected 200 100 %0d 0",
                     xpos_player2, ypos_player2, state, airborne, IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        frame(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_walk_right();
        test_limits();
        test_jump();
        test_both_keys();
        test_reset_mid_jump();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries never matched, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
